// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Command-driven initiator for an 8-bit combinational ALU with a
//            4 x 8-bit register file and a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_kind,
  input  logic [2:0] i_cmd_op,
  input  logic [1:0] i_cmd_rd,
  input  logic [1:0] i_cmd_ra,
  input  logic [1:0] i_cmd_rb,
  input  logic [7:0] i_cmd_imm,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [2:0] o_alu_sel,
  input  logic [7:0] i_alu_out,
  input  logic       i_alu_carry,
  input  logic       i_alu_zero,
  input  logic       i_alu_neg,
  input  logic       i_alu_over,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_data,
  output logic [3:0] o_rsp_flags
);

  localparam logic [1:0] c_KIND_ALU  = 2'b00;
  localparam logic [1:0] c_KIND_LOAD = 2'b01;
  localparam logic [1:0] c_KIND_CMP  = 2'b10;
  localparam logic [1:0] c_KIND_READ = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_rf [0:3];
  logic [1:0] r_kind;
  logic [2:0] r_op;
  logic [1:0] r_rd;
  logic [1:0] r_ra;
  logic [1:0] r_rb;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_sel;
  logic [7:0] r_rsp_data;
  logic [3:0] r_flags;
  logic       r_rsp_valid;
  logic       r_cmd_ready;

  // Sequencer FSM: command accept, ALU issue, result capture, response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < 4; i++) r_rf[i] <= 8'h00;
      r_kind      <= 2'b00;
      r_op        <= 3'b000;
      r_rd        <= 2'b00;
      r_ra        <= 2'b00;
      r_rb        <= 2'b00;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_sel   <= 3'b000;
      r_rsp_data  <= 8'h00;
      r_flags     <= 4'b0000;
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // ready rises on the first clock after reset and stays up while idle
          r_cmd_ready <= 1'b1;
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_kind      <= i_cmd_kind;
            r_op        <= i_cmd_op;
            r_rd        <= i_cmd_rd;
            r_ra        <= i_cmd_ra;
            r_rb        <= i_cmd_rb;
            case (i_cmd_kind)
              c_KIND_LOAD: begin
                r_rf[i_cmd_rd] <= i_cmd_imm;
                r_rsp_data     <= i_cmd_imm;
                r_rsp_valid    <= 1'b1;
                r_state        <= S_RESP;
              end
              c_KIND_READ: begin
                r_rsp_data  <= r_rf[i_cmd_ra];
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end
              default: r_state <= S_ISSUE;
            endcase
          end
        end
        S_ISSUE: begin
          // operands are read here, before any writeback, so rd aliasing sees old values
          r_alu_a   <= r_rf[r_ra];
          r_alu_b   <= r_rf[r_rb];
          r_alu_sel <= r_op;
          r_state   <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_data <= i_alu_out;
          r_flags    <= {i_alu_carry, i_alu_zero, i_alu_neg, i_alu_over};
          if (r_kind == c_KIND_ALU) r_rf[r_rd] <= i_alu_out;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // compare kind only differs from ALU kind by skipping writeback
  logic w_unused_kind_cmp;
  assign w_unused_kind_cmp = (r_kind == c_KIND_CMP);

  assign o_cmd_ready = r_cmd_ready;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_sel   = r_alu_sel;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed self-checking bench for alu_cmd_sequencer with a
//            behavioural 8-bit ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_kind;
  logic [2:0] i_cmd_op;
  logic [1:0] i_cmd_rd;
  logic [1:0] i_cmd_ra;
  logic [1:0] i_cmd_rb;
  logic [7:0] i_cmd_imm;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [2:0] o_alu_sel;
  logic [7:0] w_alu_out;
  logic       w_c, w_z, w_n, w_o;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic [3:0] o_rsp_flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_cmd_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_kind  (i_cmd_kind),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_rd    (i_cmd_rd),
    .i_cmd_ra    (i_cmd_ra),
    .i_cmd_rb    (i_cmd_rb),
    .i_cmd_imm   (i_cmd_imm),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_sel   (o_alu_sel),
    .i_alu_out   (w_alu_out),
    .i_alu_carry (w_c),
    .i_alu_zero  (w_z),
    .i_alu_neg   (w_n),
    .i_alu_over  (w_o),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_flags (o_rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: sub carry is a borrow, shift carry is the bit shifted out
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    w_c = 1'b0;
    w_o = 1'b0;
    case (o_alu_sel)
      3'b000: begin
        t = {1'b0, o_alu_a} + {1'b0, o_alu_b};
        w_c = t[8];
        w_o = (o_alu_a[7] == o_alu_b[7]) && (t[7] != o_alu_a[7]);
      end
      3'b001: begin
        t = {1'b0, o_alu_a} - {1'b0, o_alu_b};
        w_c = t[8];
        w_o = (o_alu_a[7] != o_alu_b[7]) && (t[7] != o_alu_a[7]);
      end
      3'b010: t = {1'b0, o_alu_a & o_alu_b};
      3'b011: t = {1'b0, o_alu_a | o_alu_b};
      3'b100: t = {1'b0, o_alu_a};
      3'b101: begin t = {1'b0, o_alu_a << 1}; w_c = o_alu_a[7]; end
      3'b110: begin t = {1'b0, o_alu_a >> 1}; w_c = o_alu_a[0]; end
      default: t = 9'd0;
    endcase
    w_alu_out = t[7:0];
    w_z = (t[7:0] == 8'h00);
    w_n = t[7];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command with rsp_ready high; lat counts edges from accept edge (=1) to rsp_valid
  task automatic do_cmd(input logic [1:0] k, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                        output logic [7:0] d, output logic [3:0] f, output int lat);
    int t;
    i_cmd_kind = k; i_cmd_op = op; i_cmd_rd = rd; i_cmd_ra = ra; i_cmd_rb = rb; i_cmd_imm = imm;
    i_cmd_valid = 1'b1;
    t = 0;
    while (!o_cmd_ready && t < 20) begin step(); t++; end
    if (t >= 20) chk("cmd_ready_timeout", 16'(o_cmd_ready), 16'd1);
    step();
    i_cmd_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin step(); lat++; end
    if (lat >= 20) chk("rsp_valid_timeout", 16'(o_rsp_valid), 16'd1);
    d = o_rsp_data;
    f = o_rsp_flags;
    step();
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] f;
    int lat;
    rst_n = 1'b0; i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
    i_cmd_kind = 2'b00; i_cmd_op = 3'b000; i_cmd_rd = 2'd0; i_cmd_ra = 2'd0; i_cmd_rb = 2'd0;
    i_cmd_imm = 8'h00;
    step(); step();
    chk("rst_cmd_ready", 16'(o_cmd_ready), 16'd0);
    chk("rst_rsp_valid", 16'(o_rsp_valid), 16'd0);
    chk("rst_rsp_data",  16'(o_rsp_data),  16'h00);
    chk("rst_flags",     16'(o_rsp_flags), 16'h0);
    chk("rst_alu",       {o_alu_a, o_alu_b}, 16'h0000);
    #3 rst_n = 1'b1;
    step();
    chk("ready_after_rst", 16'(o_cmd_ready), 16'd1);

    // Build nonzero state: R2=0x80, R2+R2 -> 0x00 with carry/zero/over
    do_cmd(2'b01, 3'b000, 2'd2, 2'd0, 2'd0, 8'h80, d, f, lat);
    do_cmd(2'b00, 3'b000, 2'd2, 2'd2, 2'd2, 8'h00, d, f, lat);
    chk("pre_rst_data", 16'(d), 16'h00);
    chk("pre_rst_flags", 16'(f), 16'b1101);
    do_cmd(2'b01, 3'b000, 2'd2, 2'd0, 2'd0, 8'h33, d, f, lat);

    // Reset asserted while the command is in ISSUE
    i_cmd_kind = 2'b00; i_cmd_op = 3'b101; i_cmd_rd = 2'd2; i_cmd_ra = 2'd2; i_cmd_rb = 2'd2;
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 16'(o_rsp_valid), 16'd0);
    chk("midrst_cmd_ready", 16'(o_cmd_ready), 16'd0);
    chk("midrst_flags",     16'(o_rsp_flags), 16'h0);
    chk("midrst_alu_a",     16'(o_alu_a),     16'h00);
    #3 rst_n = 1'b1;
    step();
    do_cmd(2'b11, 3'b000, 2'd0, 2'd2, 2'd0, 8'h00, d, f, lat);
    chk("read_r2_after_rst", {4'h0, f, d}, 16'h0000);

    // Load and add
    do_cmd(2'b01, 3'b000, 2'd0, 2'd0, 2'd0, 8'h7F, d, f, lat);
    chk("load_r0_data", 16'(d), 16'h7F);
    chk("load_latency", 16'(lat), 16'd1);
    do_cmd(2'b01, 3'b000, 2'd1, 2'd0, 2'd0, 8'h01, d, f, lat);
    do_cmd(2'b00, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, d, f, lat);
    chk("add_alu_a", 16'(o_alu_a), 16'h7F);
    chk("add_alu_b", 16'(o_alu_b), 16'h01);
    chk("add_alu_sel", 16'(o_alu_sel), 16'h0);
    chk("add_data", 16'(d), 16'h80);
    chk("add_flags", 16'(f), 16'b0011);
    chk("alu_latency", 16'(lat), 16'd3);
    do_cmd(2'b11, 3'b000, 2'd0, 2'd2, 2'd0, 8'h00, d, f, lat);
    chk("read_r2_add", {4'h0, f, d}, {8'h03, 8'h80});

    // Compare: sub with no writeback
    do_cmd(2'b01, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, d, f, lat);
    do_cmd(2'b01, 3'b000, 2'd1, 2'd0, 2'd0, 8'h05, d, f, lat);
    do_cmd(2'b10, 3'b001, 2'd3, 2'd0, 2'd1, 8'h00, d, f, lat);
    chk("cmp_data", 16'(d), 16'h00);
    chk("cmp_flags", 16'(f), 16'b0100);
    do_cmd(2'b11, 3'b000, 2'd0, 2'd0, 2'd0, 8'h00, d, f, lat);
    chk("cmp_r0", 16'(d), 16'h05);
    do_cmd(2'b11, 3'b000, 2'd0, 2'd1, 2'd0, 8'h00, d, f, lat);
    chk("cmp_r1", 16'(d), 16'h05);
    do_cmd(2'b11, 3'b000, 2'd0, 2'd2, 2'd0, 8'h00, d, f, lat);
    chk("cmp_r2", 16'(d), 16'h80);
    do_cmd(2'b11, 3'b000, 2'd0, 2'd3, 2'd0, 8'h00, d, f, lat);
    chk("cmp_r3", {4'h0, f, d}, {8'h04, 8'h00});

    // Aliasing rd = ra
    do_cmd(2'b01, 3'b000, 2'd3, 2'd0, 2'd0, 8'h81, d, f, lat);
    do_cmd(2'b00, 3'b110, 2'd3, 2'd3, 2'd0, 8'h00, d, f, lat);
    chk("shr_alias", {4'h0, f, d}, {8'h08, 8'h40});
    do_cmd(2'b11, 3'b000, 2'd0, 2'd3, 2'd0, 8'h00, d, f, lat);
    chk("read_r3_shr", 16'(d), 16'h40);
    do_cmd(2'b00, 3'b101, 2'd3, 2'd3, 2'd0, 8'h00, d, f, lat);
    chk("shl_alias", {4'h0, f, d}, {8'h02, 8'h80});

    // Zero op
    do_cmd(2'b00, 3'b111, 2'd1, 2'd3, 2'd3, 8'h00, d, f, lat);
    chk("zero_op", {4'h0, f, d}, {8'h04, 8'h00});
    chk("zero_latency", 16'(lat), 16'd3);

    // Back-pressure: response held 5 cycles, pending command must wait
    i_rsp_ready = 1'b0;
    i_cmd_kind = 2'b01; i_cmd_rd = 2'd0; i_cmd_imm = 8'h11; i_cmd_valid = 1'b1;
    step();
    i_cmd_imm = 8'h22;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {5'd0, o_rsp_valid, o_cmd_ready, 1'b0, o_rsp_data}, {5'd0, 1'b1, 1'b0, 1'b0, 8'h11});
      step();
    end
    i_rsp_ready = 1'b1;
    step();
    chk("bp_release", {o_rsp_valid, o_cmd_ready}, 2'b01);
    step();
    i_cmd_valid = 1'b0;
    chk("bp_next_accept", {7'd0, o_rsp_valid, o_rsp_data}, {7'd0, 1'b1, 8'h22});
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
